data_cache: RTL

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
`default_nettype none
// data_cache: direct-mapped, write-through / no-write-allocate data cache, 4-word lines.
// Loads hit combinationally; misses refill the line with 4 sequential word reads.
module data_cache #(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  mem_write,
    input  logic [1:0]            type_control,
    input  logic                  sign_ext_flag,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ready
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = DATA_WIDTH - IDX_W - 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic [1:0] beat;

    logic [DATA_WIDTH-1:0] data_arr [SETS*4];
    logic [TAG_W-1:0]      tag_arr  [SETS];
    logic [SETS-1:0]       valid;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            offset;
    logic                  hit;
    logic [DATA_WIDTH-1:0] word;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;
    logic [DATA_WIDTH-1:0] load_ext;
    logic [3:0]            store_strb;
    logic [DATA_WIDTH-1:0] store_data;

    logic [3:0]            wr_be;
    logic [IDX_W+1:0]      wr_word;
    logic [DATA_WIDTH-1:0] wr_data;

    assign idx    = addr[IDX_W+3:4];
    assign tag    = addr[DATA_WIDTH-1:IDX_W+4];
    assign offset = addr[3:2];
    assign hit    = valid[idx] && (tag_arr[idx] == tag);
    assign word   = data_arr[{idx, offset}];

    assign load_byte = word[{addr[1:0], 3'b000} +: 8];
    assign load_half = addr[1] ? word[31:16] : word[15:0];

    always_comb begin
        case (type_control)
            2'b00:   load_ext = {{(DATA_WIDTH-8){sign_ext_flag & load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{(DATA_WIDTH-16){sign_ext_flag & load_half[15]}}, load_half};
            default: load_ext = word;
        endcase
    end

    // Sub-word stores are replicated across all lanes; the strobes select the live ones.
    always_comb begin
        case (type_control)
            2'b00: begin
                store_strb = 4'b0001 << addr[1:0];
                store_data = {(DATA_WIDTH/8){write_data[7:0]}};
            end
            2'b01: begin
                store_strb = addr[1] ? 4'b1100 : 4'b0011;
                store_data = {(DATA_WIDTH/16){write_data[15:0]}};
            end
            default: begin
                store_strb = 4'b1111;
                store_data = write_data;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            beat  <= 2'd0;
            valid <= '0;
        end else begin
            state <= next_state;
            if (state == REFILL && mem_ready) begin
                beat <= beat + 2'd1;
                if (beat == 2'd3) begin
                    valid[idx] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        stall      = 1'b0;
        read_data  = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wstrb  = 4'b0000;
        wr_be      = 4'b0000;
        wr_word    = {idx, offset};
        wr_data    = store_data;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (mem_write) begin
                        stall      = 1'b1;
                        next_state = WRITE;
                    end else if (hit) begin
                        read_data = load_ext;
                    end else begin
                        stall      = 1'b1;
                        next_state = REFILL;
                    end
                end
            end
            REFILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag, idx, beat, 2'b00};
                if (mem_ready) begin
                    wr_be   = 4'b1111;
                    wr_word = {idx, beat};
                    wr_data = mem_rdata;
                    if (beat == 2'd3) begin
                        next_state = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {addr[DATA_WIDTH-1:2], 2'b00};
                mem_wdata = store_data;
                mem_wstrb = store_strb;
                stall     = ~mem_ready;
                if (mem_ready) begin
                    next_state = IDLE;
                    if (hit) begin
                        wr_be = store_strb;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && mem_ready && beat == 2'd3) begin
            tag_arr[idx] <= tag;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                data_arr[wr_word][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
    end

endmodule
`default_nettype wire
